// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel synchroniser, edge detect and
// pending latch, round-robin serialised onto one valid/ready event port.
// Optional per-event timestamps when EDGE_ARB_TIMESTAMP_EN is defined.

module edge_event_ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  input  logic [1:0] mode,
  input  logic       armed,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       det,
  output logic       pending,
  output logic       ovf
);
  logic s1, s2, s2_d;

  assign det = armed & ((mode[0] & s2_d & ~s2) | (mode[1] & ~s2_d & s2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s2_d    <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      s1      <= signal;
      s2      <= s1;
      s2_d    <= s2;
      // a new event arriving with the grant keeps the channel pending
      pending <= det | (pending & ~grant);
      if (det & pending & ~grant) ovf <= 1'b1;
      else if (ovf_clr)           ovf <= 1'b0;
    end
  end
endmodule

module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
`ifdef EDGE_ARB_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   signal,
  input  logic [2*NUM_CH-1:0] mode,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_W-1:0]     evt_id,
`ifdef EDGE_ARB_TIMESTAMP_EN
  output logic [TS_W-1:0]     evt_ts,
`endif
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   ovf,
  input  logic [NUM_CH-1:0]   ovf_clr
);
  typedef enum logic {IDLE, VALID} state_t;

  localparam logic [ID_W:0]   NCH  = NUM_CH[ID_W:0];
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_CH - 1);

  state_t              state, state_nxt;
  logic [1:0]          arm;
  logic                armed;
  logic [NUM_CH-1:0]   det, grant_vec, rot;
  logic [ID_W-1:0]     ptr, off, gnt_id;
  logic [ID_W:0]       sum;
  logic                gnt_any, load;

  assign armed     = (arm == 2'd2);
  assign evt_valid = (state == VALID);
  assign load      = gnt_any & (~evt_valid | evt_ready);
  assign grant_vec = load ? (NUM_CH'(1) << gnt_id) : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_event_ch u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .signal  (signal[i]),
      .mode    (mode[2*i+1:2*i]),
      .armed   (armed),
      .grant   (grant_vec[i]),
      .ovf_clr (ovf_clr[i]),
      .det     (det[i]),
      .pending (pending[i]),
      .ovf     (ovf[i])
    );
  end

  // rotate pending so bit 0 is the pointer channel, then pick the lowest set bit
  always_comb begin
    rot = pending;
    for (int j = 0; j < NUM_CH; j++)
      if (ptr == ID_W'(j)) rot = (pending >> j) | (pending << (NUM_CH - j));
    gnt_any = 1'b0;
    off     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) begin
        gnt_any = 1'b1;
        off     = ID_W'(k);
      end
    sum    = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= NCH) ? ID_W'(sum - NCH) : ID_W'(sum);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = VALID;
      VALID:   if (evt_ready && !gnt_any) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      arm    <= 2'd0;
      ptr    <= '0;
      evt_id <= '0;
    end else begin
      state <= state_nxt;
      if (!armed) arm <= arm + 2'd1;
      if (load) begin
        evt_id <= gnt_id;
        ptr    <= (gnt_id == LAST) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]              ts_cnt;
  logic [NUM_CH-1:0][TS_W-1:0]  stamp;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ts
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                stamp[i] <= '0;
      else if (det[i] & (~pending[i] | grant_vec[i])) stamp[i] <= ts_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      evt_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (load) evt_ts <= stamp[gnt_id];
    end
  end
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a cycle-level reference model predicts
// grants into a queue; a negedge monitor pops and compares on each handshake.
module tb_edge_event_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   signal, pending, ovf, ovf_clr;
  logic [2*N-1:0] mode;
  logic           evt_valid, evt_ready;
  logic [IW-1:0]  evt_id;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [15:0]    evt_ts;
`endif

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal    (signal),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
`ifdef EDGE_ARB_TIMESTAMP_EN
    .evt_ts    (evt_ts),
`endif
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  int checks = 0, passed = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: hist[k] is the input value sampled on clock edge k after reset
  // release; an edge sampled at edge k becomes pending at edge k+2.
  int q_exp[$];
  int hist[$];
  int glog[$];
  int n_edge, m_pend, m_ovf, m_ptr;
  bit m_valid;
  bit mon_en = 1'b0;

  task automatic model_reset();
    q_exp.delete();
    hist.delete();
    hist.push_back(0);
    n_edge = 0; m_pend = 0; m_ovf = 0; m_ptr = 0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    int g, gbit, det, a, b, md, now, prev;
    n_edge++;
    hist.push_back(int'(signal));
    g = -1;
    if ((!m_valid || evt_ready) && m_pend != 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && ((m_pend >> ((m_ptr + k) % N)) & 1) == 1) g = (m_ptr + k) % N;
    gbit = (g >= 0) ? (1 << g) : 0;
    det = 0;
    if (n_edge >= 3) begin
      a = hist[n_edge - 2];
      b = hist[n_edge - 3];
      for (int i = 0; i < N; i++) begin
        now  = (a >> i) & 1;
        prev = (b >> i) & 1;
        md   = (int'(mode) >> (2 * i)) & 3;
        if (((md & 1) != 0 && prev == 1 && now == 0) || ((md & 2) != 0 && prev == 0 && now == 1))
          det |= (1 << i);
      end
    end
    m_ovf  = (m_ovf & ~int'(ovf_clr)) | (det & m_pend & ~gbit);
    m_pend = (m_pend & ~gbit) | det;
    if (g >= 0) begin
      q_exp.push_back(g);
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("evt_valid", int'(evt_valid), int'(m_valid));
      check("pending", int'(pending), m_pend);
      check("ovf", int'(ovf), m_ovf);
      if (evt_valid) begin
        if (q_exp.size() == 0) check("evt_id_unexpected", int'(evt_id), -1);
        else begin
          check("evt_id", int'(evt_id), q_exp[0]);
          if (evt_ready) void'(q_exp.pop_front());
        end
      end
    end
  end

  task automatic cyc(int k = 1);
    repeat (k) begin
      if (rst_n && evt_valid && evt_ready) glog.push_back(int'(evt_id));
      @(posedge clk);
      if (rst_n) model_step();
      #1;
    end
  endtask

  initial begin
    int first, cnt, last, seq, c1, c3, rep;
    rst_n = 1'b1; signal = '0; mode = '0; evt_ready = 1'b0; ovf_clr = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ovf", int'(ovf), 0);

    // arming: held-high inputs with falling mode give no events
    @(posedge clk); #1;
    signal = 4'hF; mode = 8'h55; rst_n = 1'b1; mon_en = 1'b1;
    cyc(10);
    check("arm_valid", int'(evt_valid), 0);
    check("arm_ovf", int'(ovf), 0);
    check("arm_pending", int'(pending), 0);

    // single falling edge on ch0: valid exactly one cycle after T3
    evt_ready = 1'b1; signal = 4'hE; first = -1; cnt = 0; seq = -1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (evt_valid) begin
        cnt++;
        if (first < 0) first = i;
        seq = int'(evt_id);
      end
    end
    check("lat_first", first, 3);
    check("lat_count", cnt, 1);
    check("lat_id", seq, 0);

    // all channels rise together: ids 0,1,2,3 back to back
    mode = 8'hFF; signal = 4'h0;
    cyc(12);
    signal = 4'hF; first = -1; cnt = 0; seq = 0; last = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (evt_valid) begin
        cnt++;
        seq = seq * 4 + int'(evt_id);
        if (first < 0) first = i;
        last = i;
      end
    end
    check("burst_seq", seq, 27);
    check("burst_count", cnt, 4);
    check("burst_consecutive", last - first, 3);
    check("burst_pending", int'(pending), 0);

    // overflow on ch2 with a stalled consumer
    mode = 8'h55; evt_ready = 1'b0; signal = 4'hF; cyc(4);
    signal = 4'hB; cyc(6);
    signal = 4'hF; cyc(2); signal = 4'hB; cyc(4);
    signal = 4'hF; cyc(2); signal = 4'hB; cyc(4);
    check("ovf_valid", int'(evt_valid), 1);
    check("ovf_id", int'(evt_id), 2);
    check("ovf_set", int'(ovf), 4);
    check("ovf_pending", int'(pending), 4);
    ovf_clr = 4'h4; cyc(); ovf_clr = '0;
    check("ovf_clr", int'(ovf), 0);
    signal = 4'hF; cyc(2); signal = 4'hB; cyc(2);
    ovf_clr = 4'h4; cyc(); ovf_clr = '0;
    check("ovf_set_wins", int'(ovf), 4);
    evt_ready = 1'b1; cyc(8);
    ovf_clr = 4'h4; cyc(); ovf_clr = '0;

    // fairness between ch1 and ch3, then ch3 disabled
    glog.delete();
    for (int r = 0; r < 12; r++) begin
      signal = (r % 2 == 1) ? 4'h5 : 4'hF;
      repeat (2) begin evt_ready = ~evt_ready; cyc(); end
    end
    evt_ready = 1'b1; cyc(8);
    c1 = 0; c3 = 0; rep = 0;
    foreach (glog[i]) begin
      if (glog[i] == 1) c1++;
      if (glog[i] == 3) c3++;
      if (i > 0 && glog[i] == glog[i-1]) rep++;
    end
    check("fair_ch1", int'(c1 >= 4), 1);
    check("fair_ch3", int'(c3 >= 4), 1);
    check("fair_alternate", rep, 0);
    mode = 8'h15;
    for (int r = 0; r < 24; r++) begin
      if (r == 4) glog.delete();
      signal = (r % 2 == 1) ? 4'h5 : 4'hF;
      repeat (2) begin evt_ready = ~evt_ready; cyc(); end
    end
    c1 = 0; c3 = 0;
    foreach (glog[i]) begin
      if (glog[i] == 1) c1++;
      if (glog[i] == 3) c3++;
    end
    check("disabled_ch3", c3, 0);
    check("enabled_ch1", int'(c1 >= 4), 1);

    // randomized traffic against the model
    mode = 8'($urandom);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) signal = signal ^ (4'(1) << $urandom_range(N-1));
      if ($urandom_range(63) == 0) mode = 8'($urandom);
      evt_ready = ($urandom_range(2) != 0);
      ovf_clr = ($urandom_range(7) == 0) ? (4'(1) << $urandom_range(N-1)) : 4'h0;
      cyc();
    end

    // asynchronous reset while an event is presented
    evt_ready = 1'b0; ovf_clr = '0; mode = 8'hFF; signal = ~signal;
    cyc(6);
    check("pre_rst_valid", int'(evt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_ovf", int'(ovf), 0);
    check("async_rst_id", int'(evt_id), 0);
    model_reset();
    cyc(2);
    rst_n = 1'b1; evt_ready = 1'b1;
    cyc(20);
    check("drain", q_exp.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
